// File: rtl/nios_system_hex_arb.sv
// nios_system_hex_arb: round-robin two-port arbiter in front of the HEX PIO
// Avalon-MM register port. Port A is the Nios II data master and port B is
// the note-display engine. Each granted transfer takes three cycles:
// IDLE (arbitrate), ISSUE (PIO access) and DONE (acknowledge).
// Optional feature macro: HEX_ARB_STATS_EN adds per-port transfer counters,
// which port A reads or clears locally at address 3.
module nios_system_hex_arb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_chipselect,
    input  logic              a_write_n,
    input  logic [DATA_W-1:0] a_writedata,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_waitrequest,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_chipselect,
    input  logic              b_write_n,
    input  logic [DATA_W-1:0] b_writedata,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_waitrequest,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_d;
    logic              cs_d;
    logic              wn_d;
    logic [DATA_W-1:0] wd_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              win_c;

`ifdef HEX_ARB_STATS_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             local_q, local_d;
    logic             local_c;
`endif

    // Winner: the sole requester, or on a tie the port not granted last
    assign win_c = (a_chipselect & b_chipselect) ? ~last_q : b_chipselect;

`ifdef HEX_ARB_STATS_EN
    // Port A at address 3 is served from the counters instead of the PIO
    assign local_c = (win_c == GNT_A) && (a_address == ADDR_W'(3));
`endif

    // Next-state, master command and read-register logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = m_address;
        cs_d    = 1'b0;
        wn_d    = m_write_n;
        wd_d    = m_writedata;
        rd_d    = rd_q;
`ifdef HEX_ARB_STATS_EN
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        local_d = local_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (a_chipselect | b_chipselect) begin
                    state_d = S_ISSUE;
                    grant_d = win_c;
                    last_d  = win_c;
                    addr_d  = win_c ? b_address   : a_address;
                    wn_d    = win_c ? b_write_n   : a_write_n;
                    wd_d    = win_c ? b_writedata : a_writedata;
`ifdef HEX_ARB_STATS_EN
                    local_d = local_c;
                    cs_d    = ~local_c;
`else
                    cs_d    = 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_DONE;
`ifdef HEX_ARB_STATS_EN
                if (local_q) begin
                    rd_d = DATA_W'({cnt_b_q, cnt_a_q});
                    if (!m_write_n) begin
                        cnt_a_d = '0;
                        cnt_b_d = '0;
                    end
                end else begin
                    rd_d = m_readdata;
                end
`else
                rd_d = m_readdata;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef HEX_ARB_STATS_EN
                if (!local_q) begin
                    if (grant_q == GNT_A && cnt_a_q != '1)
                        cnt_a_d = cnt_a_q + CNT_W'(1);
                    if (grant_q == GNT_B && cnt_b_q != '1)
                        cnt_b_d = cnt_b_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered master-port outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= GNT_A;
            last_q       <= GNT_B;
            m_address    <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
            rd_q         <= '0;
`ifdef HEX_ARB_STATS_EN
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            local_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            m_address    <= addr_d;
            m_chipselect <= cs_d;
            m_write_n    <= wn_d;
            m_writedata  <= wd_d;
            rd_q         <= rd_d;
`ifdef HEX_ARB_STATS_EN
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            local_q      <= local_d;
`endif
        end
    end

    // Acknowledge and read data go only to the granted port in DONE
    assign a_waitrequest = a_chipselect & ~(state_q == S_DONE && grant_q == GNT_A);
    assign b_waitrequest = b_chipselect & ~(state_q == S_DONE && grant_q == GNT_B);
    assign a_readdata    = (state_q == S_DONE && grant_q == GNT_A) ? rd_q : '0;
    assign b_readdata    = (state_q == S_DONE && grant_q == GNT_B) ? rd_q : '0;

endmodule

// File: tb/tb_nios_system_hex_arb.sv
// Directed testbench for nios_system_hex_arb with a small HEX PIO model.
module tb_nios_system_hex_arb;

    logic        clk;
    logic        reset_n;
    logic [1:0]  a_address, b_address, m_address;
    logic        a_chipselect, b_chipselect, m_chipselect;
    logic        a_write_n, b_write_n, m_write_n;
    logic [31:0] a_writedata, b_writedata, m_writedata;
    logic [31:0] a_readdata, b_readdata, m_readdata;
    logic        a_waitrequest, b_waitrequest;
    logic [31:0] pio_out;

    int n_checks = 0;
    int n_pass   = 0;

    nios_system_hex_arb #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_address), .a_chipselect(a_chipselect), .a_write_n(a_write_n),
        .a_writedata(a_writedata), .a_readdata(a_readdata), .a_waitrequest(a_waitrequest),
        .b_address(b_address), .b_chipselect(b_chipselect), .b_write_n(b_write_n),
        .b_writedata(b_writedata), .b_readdata(b_readdata), .b_waitrequest(b_waitrequest),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // HEX PIO model: output register at address 0, zero-latency readdata
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio_out <= '0;
        else if (m_chipselect && !m_write_n && m_address == 2'd0) pio_out <= m_writedata;
    end
    assign m_readdata = (m_address == 2'd0) ? pio_out : 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One handshake on a port; waits = 99 when no acknowledge arrives
    task automatic xfer(input bit pb, input logic [1:0] addr, input bit wr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int waits, output bit cs_seen, output bit other_nz);
        bit got;
        got = 0; waits = 0; cs_seen = 0; other_nz = 0; rd = '0;
        @(posedge clk); #1;
        if (pb) begin
            b_address = addr; b_write_n = ~wr; b_writedata = wd; b_chipselect = 1'b1;
        end else begin
            a_address = addr; a_write_n = ~wr; a_writedata = wd; a_chipselect = 1'b1;
        end
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (m_chipselect) cs_seen = 1;
            if ((pb ? a_readdata : b_readdata) != 32'd0) other_nz = 1;
            if (pb ? b_waitrequest : a_waitrequest) waits++;
            else begin
                got = 1;
                rd  = pb ? b_readdata : a_readdata;
            end
        end
        if (!got) waits = 99;
        @(posedge clk); #1;
        a_chipselect = 1'b0; a_write_n = 1'b1;
        b_chipselect = 1'b0; b_write_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_seq [8];
        int waits, a_n, b_n, k, aw, bw;
        bit cs_seen, other_nz, a_ack, b_ack;

        reset_n = 1'b0;
        a_address = '0; a_chipselect = 1'b0; a_write_n = 1'b1; a_writedata = '0;
        b_address = '0; b_chipselect = 1'b0; b_write_n = 1'b1; b_writedata = '0;

        // Reset values
        @(negedge clk);
        chk("rst_m_cs", 32'(m_chipselect), 32'd0);
        chk("rst_m_wn", 32'(m_write_n), 32'd1);
        chk("rst_m_addr", 32'(m_address), 32'd0);
        chk("rst_m_wd", m_writedata, 32'd0);
        chk("rst_a_rd", a_readdata, 32'd0);
        chk("rst_b_rd", b_readdata, 32'd0);
        chk("rst_waits", 32'({a_waitrequest, b_waitrequest}), 32'd0);
        do_reset();

        // Single write from A
        @(posedge clk); #1;
        a_address = 2'd0; a_write_n = 1'b0; a_writedata = 32'h5A; a_chipselect = 1'b1;
        @(negedge clk);
        chk("w1_c1_wait", 32'(a_waitrequest), 32'd1);
        chk("w1_c1_cs", 32'(m_chipselect), 32'd0);
        @(negedge clk);
        chk("w1_c2_cs", 32'(m_chipselect), 32'd1);
        chk("w1_c2_wd", m_writedata, 32'h5A);
        chk("w1_c2_wn", 32'(m_write_n), 32'd0);
        chk("w1_c2_wait", 32'(a_waitrequest), 32'd1);
        @(negedge clk);
        chk("w1_c3_cs", 32'(m_chipselect), 32'd0);
        chk("w1_c3_wait", 32'(a_waitrequest), 32'd0);
        chk("w1_pio", pio_out, 32'h5A);
        @(posedge clk); #1;
        a_chipselect = 1'b0; a_write_n = 1'b1;
        @(negedge clk);
        chk("w1_idle_cs", 32'(m_chipselect), 32'd0);

        // Tie after reset: A first, B second
        do_reset();
        @(posedge clk); #1;
        a_address = 2'd0; a_write_n = 1'b0; a_writedata = 32'h11; a_chipselect = 1'b1;
        b_address = 2'd0; b_write_n = 1'b0; b_writedata = 32'h22; b_chipselect = 1'b1;
        @(negedge clk);
        chk("tie_c1_waits", 32'({a_waitrequest, b_waitrequest}), 32'd3);
        @(negedge clk);
        chk("tie_c2_cs", 32'(m_chipselect), 32'd1);
        chk("tie_c2_wd", m_writedata, 32'h11);
        @(negedge clk);
        chk("tie_c3_waits", 32'({a_waitrequest, b_waitrequest}), 32'd1);
        @(posedge clk); #1;
        a_chipselect = 1'b0; a_write_n = 1'b1;
        @(negedge clk);
        chk("tie_c4_bwait", 32'(b_waitrequest), 32'd1);
        @(negedge clk);
        chk("tie_c5_cs", 32'(m_chipselect), 32'd1);
        chk("tie_c5_wd", m_writedata, 32'h22);
        chk("tie_c5_bwait", 32'(b_waitrequest), 32'd1);
        @(negedge clk);
        chk("tie_c6_bwait", 32'(b_waitrequest), 32'd0);
        @(posedge clk); #1;
        b_chipselect = 1'b0; b_write_n = 1'b1;
        @(negedge clk);
        chk("tie_pio", pio_out, 32'h22);

        // Round-robin: both ports stream 4 writes each
        for (int i = 0; i < 4; i++) begin
            exp_seq[2*i]   = 32'hA0 + 32'(i);
            exp_seq[2*i+1] = 32'hB0 + 32'(i);
        end
        a_n = 0; b_n = 0; k = 0; aw = 0; bw = 0;
        @(posedge clk); #1;
        a_address = 2'd0; a_write_n = 1'b0; a_writedata = 32'hA0; a_chipselect = 1'b1;
        b_address = 2'd0; b_write_n = 1'b0; b_writedata = 32'hB0; b_chipselect = 1'b1;
        for (int cyc = 0; cyc < 80 && (a_n < 4 || b_n < 4); cyc++) begin
            @(negedge clk);
            if (m_chipselect) begin
                if (k < 8) chk("rr_order", m_writedata, exp_seq[k]);
                k++;
            end
            a_ack = 0; b_ack = 0;
            if (a_chipselect) begin
                if (a_waitrequest) aw++;
                else begin chk("rr_wait_a", 32'(aw <= 5), 32'd1); aw = 0; a_ack = 1; end
            end
            if (b_chipselect) begin
                if (b_waitrequest) bw++;
                else begin chk("rr_wait_b", 32'(bw <= 5), 32'd1); bw = 0; b_ack = 1; end
            end
            @(posedge clk); #1;
            if (a_ack) begin
                a_n++;
                if (a_n < 4) a_writedata = 32'hA0 + 32'(a_n);
                else begin a_chipselect = 1'b0; a_write_n = 1'b1; end
            end
            if (b_ack) begin
                b_n++;
                if (b_n < 4) b_writedata = 32'hB0 + 32'(b_n);
                else begin b_chipselect = 1'b0; b_write_n = 1'b1; end
            end
        end
        chk("rr_complete", 32'({a_n == 4, b_n == 4, k == 8}), 32'd7);

        // Read-back: B writes, A reads
        xfer(1'b1, 2'd0, 1'b1, 32'h7F, rd, waits, cs_seen, other_nz);
        chk("rb_bw_waits", 32'(waits), 32'd2);
        xfer(1'b0, 2'd0, 1'b0, 32'h0, rd, waits, cs_seen, other_nz);
        chk("rb_a_rd", rd, 32'h0000007F);
        chk("rb_a_waits", 32'(waits), 32'd2);
        chk("rb_b_rd_zero", 32'(other_nz), 32'd0);
        chk("rb_cs_seen", 32'(cs_seen), 32'd1);

        // Reset asserted during ISSUE
        @(posedge clk); #1;
        a_address = 2'd0; a_write_n = 1'b0; a_writedata = 32'h33; a_chipselect = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mr_issue_cs", 32'(m_chipselect), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mr_cs_drop", 32'(m_chipselect), 32'd0);
        chk("mr_wn", 32'(m_write_n), 32'd1);
        #1 a_chipselect = 1'b0; a_write_n = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("mr_pio", pio_out, 32'd0);
        chk("mr_waits", 32'({a_waitrequest, b_waitrequest}), 32'd0);
        chk("mr_idle_cs", 32'(m_chipselect), 32'd0);
        #1 b_chipselect = 1'b1;
        #1;
        chk("mr_b_wait_follow", 32'({a_waitrequest, b_waitrequest}), 32'd1);
        #1 b_chipselect = 1'b0;
        #1;
        chk("mr_b_wait_low", 32'(b_waitrequest), 32'd0);

`ifdef HEX_ARB_STATS_EN
        // Counters: 3 A + 2 B transfers, then local read and clear
        for (int i = 0; i < 3; i++) xfer(1'b0, 2'd1, 1'b1, 32'(i), rd, waits, cs_seen, other_nz);
        for (int i = 0; i < 2; i++) xfer(1'b1, 2'd1, 1'b1, 32'(i), rd, waits, cs_seen, other_nz);
        xfer(1'b0, 2'd3, 1'b0, 32'h0, rd, waits, cs_seen, other_nz);
        chk("st_read", rd, 32'h00020003);
        chk("st_no_cs", 32'(cs_seen), 32'd0);
        chk("st_waits", 32'(waits), 32'd2);
        xfer(1'b0, 2'd3, 1'b1, 32'h0, rd, waits, cs_seen, other_nz);
        chk("st_clr_no_cs", 32'(cs_seen), 32'd0);
        xfer(1'b0, 2'd3, 1'b0, 32'h0, rd, waits, cs_seen, other_nz);
        chk("st_after_clr", rd, 32'd0);
        xfer(1'b1, 2'd3, 1'b0, 32'h0, rd, waits, cs_seen, other_nz);
        chk("st_b_fwd_cs", 32'(cs_seen), 32'd1);
        chk("st_b_fwd_rd", rd, 32'd0);
`else
        // Address 3 goes to the PIO from both ports
        xfer(1'b0, 2'd3, 1'b0, 32'h0, rd, waits, cs_seen, other_nz);
        chk("a3_a_cs", 32'(cs_seen), 32'd1);
        chk("a3_a_rd", rd, 32'd0);
        xfer(1'b1, 2'd3, 1'b0, 32'h0, rd, waits, cs_seen, other_nz);
        chk("a3_b_cs", 32'(cs_seen), 32'd1);
        chk("a3_b_waits", 32'(waits), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nios_system_hex_arb.md
# nios_system_hex_arb

Two-port arbiter that shares the single Avalon-MM register port of a HEX display output PIO between the Nios II data master (port A) and a hardware note-display engine (port B). Each requester sees an Avalon-MM slave with waitrequest. The arbiter serialises their transfers onto one registered master port that drives the PIO's `address`/`chipselect`/`write_n`/`writedata` and samples its zero-latency `readdata`. Grants are round-robin, one transfer per grant.

## Interface
Parameters:
- `DATA_W`, 32: data width on all three ports.
- `ADDR_W`, 2: address width on all three ports.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_address`  in  ADDR_W  port A word address.
- `a_chipselect`  in  1  port A transfer request.
- `a_write_n`  in  1  port A: 0 = write, 1 = read.
- `a_writedata`  in  DATA_W  port A write data.
- `a_readdata`  out  DATA_W  port A read data; valid in the cycle `a_waitrequest` is low.
- `a_waitrequest`  out  1  port A stall.
- `b_address`, `b_chipselect`, `b_write_n`, `b_writedata`, `b_readdata`, `b_waitrequest`: same as port A, for port B.
- `m_address`  out  ADDR_W  to the PIO `address`.
- `m_chipselect`  out  1  to the PIO `chipselect`.
- `m_write_n`  out  1  to the PIO `write_n`.
- `m_writedata`  out  DATA_W  to the PIO `writedata`.
- `m_readdata`  in  DATA_W  from the PIO `readdata` (combinational, zero latency).

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE**
  - If any `x_chipselect` is high, pick a winner and go to ISSUE.
  - Winner is the single requester if only one is active.
  - If both are active, the winner is the port not granted last.
  - `last_grant` resets to B, so A wins the first tie.
  - On entry to ISSUE, register the winner's address, write_n and writedata into `m_*`, and update `last_grant`.
- **ISSUE**
  - `m_chipselect`=1 for exactly this cycle.
  - Capture `m_readdata` into a shared read register at the clock edge. The register is updated on writes too.
  - Go to DONE.
- **DONE**
  - `m_chipselect`=0.
  - Winner's waitrequest goes low and its readdata shows the captured register.
  - Return to IDLE.
- **Waitrequest:** `x_waitrequest = x_chipselect & ~(state==DONE & grant==x)`.
  - Combinational.
  - Low whenever that port's chipselect is low.
- **Loser:** its waitrequest stays high; it is served on the next arbitration.
  - A back-to-back request from the same winner does not starve the other port.
- **Command capture:** the command is taken at the IDLE sample. Changes to a requester's signals while it is stalled are ignored. Avalon requires them stable.
- **Chipselect dropped mid-transfer:** the PIO access still completes and nothing is acknowledged.
- **`x_readdata`:** zero when that port is not in DONE with grant.

## Timing
- **Reset values:**
  - `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
  - Read register = 0, state = IDLE.
  - Both `x_readdata` = 0.
- **Uncontended transfer:** request seen at edge N → `m_chipselect` high in cycle N+1 → `x_waitrequest` low in cycle N+2 (2 wait cycles) → next arbitration at N+3.
- **Throughput:** one transfer per 3 cycles, total across both ports.
- **Contended request:** waits at most one extra transfer, i.e. 5 wait cycles.
- **Reset asserted mid-transfer:**
  - `m_chipselect` drops immediately (asynchronous).
  - The in-flight command is abandoned and state goes to IDLE.
  - The PIO itself is reset by the same `reset_n`.

## Configuration
- `HEX_ARB_STATS_EN` defined:
  - Two 16-bit saturating counters count completed transfers, one for A and one for B. They saturate at 0xFFFF.
  - A port-A access to address 3 is served locally: same 3-cycle handshake, `m_chipselect` stays 0 in ISSUE.
  - A read there returns {count_B, count_A}.
  - A write there clears both counters.
  - Local accesses are not counted.
  - Port-B accesses to address 3 are forwarded normally.
- `HEX_ARB_STATS_EN` undefined:
  - No counters.
  - Address 3 from either port is forwarded to the PIO, which returns 0.

## Test plan
- **Single write:** A writes 0x5A to address 0 after reset → `m_chipselect` high for exactly 1 cycle with `m_writedata`=0x5A and `m_write_n`=0; `a_waitrequest` high 2 cycles, low on the 3rd; the PIO output reads 0x5A.
- **Tie after reset:** A and B both request in the same cycle (A writes 0x11, B writes 0x22) → A is issued first and B second; PIO output ends at 0x22; `b_waitrequest` high for 5 cycles.
- **Round-robin:** A and B both continuously request 4 transfers each → `m_*` grants alternate A, B, A, B, …; neither port waits more than 5 cycles.
- **Read-back:** B writes 0x7F, then A reads address 0 → `a_readdata`=0x0000007F in the DONE cycle; `b_readdata`=0 throughout A's transfer.
- **Reset mid-transfer:** assert `reset_n`=0 during ISSUE → `m_chipselect`=0 within the same cycle; after release the state is IDLE, the PIO output is 0, and both waitrequests follow their chipselects.
- **Stats (`HEX_ARB_STATS_EN`):** 3 A transfers + 2 B transfers, then A reads address 3 → 0x00020003 with no `m_chipselect` pulse; A writes address 3 → a subsequent read returns 0.
